ttm_frame_packer: RTL and testbench

- Consumes the 32-bit show-ahead word stream from the prefetch FIFO stage (top/second/third valid flags plus read strobe).
- Wraps the words into framed bursts: a header word, up to FRAME_LEN payload words, then a trailer word carrying count and checksum.
- Presents frames on a registered valid/ready stream to the host-link transmitter.
- Closes short frames on an idle timeout, so sparse photon data still reaches the host.

---
 rtl/ttm_frame_pkg.sv | 43 ++++
 rtl/ttm_out_reg.sv | 45 ++++
 rtl/ttm_frame_packer.sv | 141 ++++++++++++++
 tb/tb_ttm_frame_packer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttm_frame_pkg.sv
// Shared types and helpers for the frame packer: FSM states, header/trailer field layout, checksum fold.
// Latency: none (types and pure functions only). Backpressure: not applicable.
package ttm_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;

  localparam logic [7:0] TRAILER_TAG = 8'hF0;

  // Header:  [31:16] sync marker, [15:8] frame sequence, [7:0] zero
  localparam int HDR_SYNC_LSB = 16;
  localparam int HDR_SEQ_LSB  = 8;

  // Trailer: [31:24] tag, [23:16] payload word count, [15:0] folded checksum
  localparam int TRL_TAG_LSB  = 24;
  localparam int TRL_CNT_LSB  = 16;
  localparam int TRL_CSUM_LSB = 0;

  function automatic logic [15:0] fold_csum(input logic [31:0] csum);
    return csum[31:16] ^ csum[15:0];
  endfunction

  function automatic logic [31:0] make_header(input logic [15:0] sync, input logic [7:0] seq);
    logic [31:0] hdr;
    hdr                        = '0;
    hdr[HDR_SYNC_LSB +: 16]    = sync;
    hdr[HDR_SEQ_LSB  +: 8]     = seq;
    return hdr;
  endfunction

  function automatic logic [31:0] make_trailer(input logic [7:0] cnt, input logic [31:0] csum);
    logic [31:0] trl;
    trl                        = '0;
    trl[TRL_TAG_LSB  +: 8]     = TRAILER_TAG;
    trl[TRL_CNT_LSB  +: 8]     = cnt;
    trl[TRL_CSUM_LSB +: 16]    = fold_csum(csum);
    return trl;
  endfunction

endpackage

// File: rtl/ttm_out_reg.sv
// One-entry registered valid/ready output stage; loaded words appear one cycle later.
// Backpressure: a held word stays put while out_rdy_i=0; slot_free_o tells the producer when it may load.
module ttm_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_dat_i,
  output logic         slot_free_o,
  output logic [W-1:0] out_dat_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign slot_free_o = ~vld_q | out_rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (slot_free_o) begin
      vld_d = load_i;
      if (load_i) begin
        dat_d = load_dat_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_dat_o = dat_q;
  assign out_vld_o = vld_q;

endmodule

// File: rtl/ttm_frame_packer.sv
// Wraps a show-ahead word stream into header / payload / trailer frames; idle timeout closes short frames.
// Latency: popped word or header is on out_data_o one cycle later. Backpressure: pops only when the output slot is free.
module ttm_frame_packer
  import ttm_frame_pkg::*;
#(
  parameter int          FRAME_LEN   = 64,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] SYNC_WORD   = 16'hCAFE
) (
  input  logic        data_clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_top_i,
  input  logic        in_valid_second_i,
  input  logic        in_valid_third_i,
  output logic        in_read_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o
);

  localparam int              IDLE_W    = $clog2(TIMEOUT_CYC);
  localparam logic [7:0]      LEN_LAST  = 8'(FRAME_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [7:0]          seq_q, seq_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]          count_q, count_d;
  logic [31:0]         csum_q, csum_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic                slot_free;
  logic                load;
  logic [31:0]         load_dat;
  logic                pop;
  logic                any_valid;

  assign any_valid = in_valid_top_i | in_valid_second_i | in_valid_third_i;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    count_d     = count_q;
    csum_d      = csum_q;
    idle_cnt_d  = idle_cnt_q;
    load        = 1'b0;
    load_dat    = '0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        // Header is loaded without popping, so the frame always has at least one word behind it.
        if (enable_i && in_valid_top_i && slot_free) begin
          load       = 1'b1;
          load_dat   = make_header(SYNC_WORD, seq_q);
          count_d    = '0;
          csum_d     = '0;
          idle_cnt_d = '0;
          state_d    = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (in_valid_top_i && slot_free) begin
          pop        = 1'b1;
          load       = 1'b1;
          load_dat   = in_data_i;
          count_d    = count_q + 8'd1;
          csum_d     = csum_q ^ in_data_i;
          idle_cnt_d = '0;
          if (count_q == LEN_LAST || !enable_i) begin
            state_d = TRAILER;
          end
        end else if (!enable_i && !in_valid_top_i) begin
          state_d = TRAILER;
        end else if (!any_valid) begin
          // Words still in flight upstream or stalled by backpressure do not count as idle.
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = TRAILER;
          end
        end
      end

      TRAILER: begin
        if (slot_free) begin
          load        = 1'b1;
          load_dat    = make_trailer(count_q, csum_q);
          seq_d       = seq_q + 8'd1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      count_q     <= '0;
      csum_q      <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  ttm_out_reg #(
    .W (32)
  ) u_out_reg (
    .clk         (data_clk),
    .rst         (reset),
    .load_i      (load),
    .load_dat_i  (load_dat),
    .slot_free_o (slot_free),
    .out_dat_o   (out_data_o),
    .out_vld_o   (out_valid_o),
    .out_rdy_i   (out_ready_i)
  );

  assign in_read_o   = pop;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ttm_frame_packer.sv
// Bench for ttm_frame_packer: show-ahead upstream queue model, output capture, and an expected
// stream built from frame lengths and the input word order.
module tb_ttm_frame_packer;

  localparam int FL0 = 64;
  localparam int TO0 = 1024;
  localparam int FL1 = 1;
  localparam int TO1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        rdy;
  logic [31:0] din;
  logic        vt, vs, vth;
  logic        sel;

  logic        en0, vt0, vs0, vth0, rdy0, rd0, ov0, bz0;
  logic        en1, vt1, vs1, vth1, rdy1, rd1, ov1, bz1;
  logic [31:0] od0, od1;
  logic [15:0] fc0, fc1;

  assign en0  = ~sel & en;
  assign vt0  = ~sel & vt;
  assign vs0  = ~sel & vs;
  assign vth0 = ~sel & vth;
  assign rdy0 = sel | rdy;
  assign en1  = sel & en;
  assign vt1  = sel & vt;
  assign vs1  = sel & vs;
  assign vth1 = sel & vth;
  assign rdy1 = ~sel | rdy;

  logic        rd, ov, bz;
  logic [31:0] od;
  logic [15:0] fc;
  assign rd = sel ? rd1 : rd0;
  assign ov = sel ? ov1 : ov0;
  assign bz = sel ? bz1 : bz0;
  assign od = sel ? od1 : od0;
  assign fc = sel ? fc1 : fc0;

  ttm_frame_packer #(.FRAME_LEN(FL0), .TIMEOUT_CYC(TO0), .SYNC_WORD(16'hCAFE)) dut0 (
    .data_clk(clk), .reset(rst), .enable_i(en0), .in_data_i(din),
    .in_valid_top_i(vt0), .in_valid_second_i(vs0), .in_valid_third_i(vth0),
    .in_read_o(rd0), .out_data_o(od0), .out_valid_o(ov0), .out_ready_i(rdy0),
    .frame_cnt_o(fc0), .busy_o(bz0));

  ttm_frame_packer #(.FRAME_LEN(FL1), .TIMEOUT_CYC(TO1), .SYNC_WORD(16'hCAFE)) dut1 (
    .data_clk(clk), .reset(rst), .enable_i(en1), .in_data_i(din),
    .in_valid_top_i(vt1), .in_valid_second_i(vs1), .in_valid_third_i(vth1),
    .in_read_o(rd1), .out_data_o(od1), .out_valid_o(ov1), .out_ready_i(rdy1),
    .frame_cnt_o(fc1), .busy_o(bz1));

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          pops;
  int          drop_at;
  int          feed_left;
  bit          rand_rdy;
  logic        prev_stall;
  logic [31:0] prev_dat;
  logic [31:0] up_q[$];
  logic [31:0] cap_q[$];
  int          cap_cyc[$];
  int          exp_len[$];
  logic [31:0] exp_words[$];
  logic [31:0] exp_q[$];

  task automatic drive_up();
    vt  = (up_q.size() > 0);
    vs  = (up_q.size() > 1);
    vth = (up_q.size() > 2);
    din = (up_q.size() > 0) ? up_q[0] : 32'h0;
  endtask

  task automatic top_up();
    logic [31:0] w;
    while (feed_left > 0 && up_q.size() < 4) begin
      w = $urandom;
      up_q.push_back(w);
      exp_words.push_back(w);
      feed_left--;
    end
  endtask

  // One clock: observe at negedge, then update upstream and ready just after posedge.
  task automatic step();
    logic pop_now;
    @(negedge clk);
    if (prev_stall) begin
      checks++;
      if (ov !== 1'b1 || od !== prev_dat) begin
        errors++;
        $display("FAIL hold_stable cyc %0d got vld=%b dat=%h required vld=1 dat=%h", cyc, ov, od, prev_dat);
      end
    end
    prev_stall = ov & ~rdy;
    prev_dat   = od;
    if (ov && rdy) begin
      cap_q.push_back(od);
      cap_cyc.push_back(cyc);
    end
    pop_now = rd;
    if (pop_now) begin
      pops++;
      if (drop_at != 0 && pops == drop_at) en = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now && !rst && up_q.size() > 0) void'(up_q.pop_front());
    rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    top_up();
    drive_up();
  endtask

  task automatic run_idle(input int max_cyc, input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((bz || ov) && n < max_cyc);
    checks++;
    if (bz || ov) begin
      errors++;
      $display("FAIL %s_drain busy=%b vld=%b after %0d cycles, required both 0", nm, bz, ov, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_q.delete(); cap_q.delete(); cap_cyc.delete();
    exp_len.delete(); exp_words.delete();
    pops = 0; drop_at = 0; feed_left = 0; prev_stall = 1'b0;
    en = 1'b0; rand_rdy = 1'b0; rdy = 1'b1;
    drive_up();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic build_exp();
    int w;
    logic [31:0] x;
    w = 0;
    exp_q.delete();
    foreach (exp_len[f]) begin
      x = 32'h0;
      exp_q.push_back({16'hCAFE, 8'(f), 8'h00});
      for (int i = 0; i < exp_len[f]; i++) begin
        exp_q.push_back(exp_words[w]);
        x = x ^ exp_words[w];
        w++;
      end
      exp_q.push_back({8'hF0, 8'(exp_len[f]), x[31:16] ^ x[15:0]});
    end
  endtask

  task automatic compare_stream(input string nm);
    build_exp();
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_beats got %0d required %0d", nm, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat%0d got %h required %h", nm, i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; en = 1'b0; rdy = 1'b1; rand_rdy = 1'b0;
    up_q.delete(); drive_up();
    #1;
    checks++;
    if (ov0 !== 1'b0 || od0 !== 32'h0 || rd0 !== 1'b0 || bz0 !== 1'b0 || fc0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_dut0 got vld=%b dat=%h rd=%b busy=%b fcnt=%h required all 0", ov0, od0, rd0, bz0, fc0);
    end
    checks++;
    if (ov1 !== 1'b0 || od1 !== 32'h0 || rd1 !== 1'b0 || bz1 !== 1'b0 || fc1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_dut1 got vld=%b dat=%h rd=%b busy=%b fcnt=%h required all 0", ov1, od1, rd1, bz1, fc1);
    end
  endtask

  task automatic test_full_frame();
    int first, last;
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      up_q.push_back(32'(i));
      exp_words.push_back(32'(i));
    end
    exp_len.push_back(64);
    en = 1'b1;
    drive_up();
    run_idle(300, "full");
    compare_stream("full");
    first = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
    last  = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -1;
    checks++;
    if (first !== 1) begin
      errors++;
      $display("FAIL full_hdr_latency got cycle %0d required 1", first);
    end
    checks++;
    if (last - first !== 65) begin
      errors++;
      $display("FAIL full_span got %0d required 65", last - first);
    end
    checks++;
    if (fc !== 16'd1) begin
      errors++;
      $display("FAIL full_frame_cnt got %0d required 1", fc);
    end
  endtask

  task automatic test_timeout();
    int gap;
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      up_q.push_back(w);
      exp_words.push_back(w);
    end
    exp_len.push_back(3);
    en = 1'b1;
    drive_up();
    run_idle(1300, "timeout");
    compare_stream("timeout");
    // Last payload word shows the cycle after its pop; TIMEOUT idle cycles, then the trailer load cycle.
    gap = (cap_cyc.size() >= 2) ? cap_cyc[cap_cyc.size()-1] - cap_cyc[cap_cyc.size()-2] : -1;
    checks++;
    if (gap !== TO0 + 1) begin
      errors++;
      $display("FAIL timeout_gap got %0d required %0d", gap, TO0 + 1);
    end
    checks++;
    if (bz !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy got %b required 0", bz);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    feed_left = 3 * FL0;
    for (int f = 0; f < 3; f++) exp_len.push_back(FL0);
    rand_rdy = 1'b1;
    en = 1'b1;
    top_up();
    drive_up();
    run_idle(3000, "bp");
    compare_stream("bp");
    checks++;
    if (fc !== 16'd3) begin
      errors++;
      $display("FAIL bp_frame_cnt got %0d required 3", fc);
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      up_q.push_back(w);
      exp_words.push_back(w);
    end
    exp_len.push_back(10);
    exp_len.push_back(54);
    drop_at = 10;
    en = 1'b1;
    drive_up();
    run_idle(300, "en_drop");
    repeat (50) step();
    checks++;
    if (cap_q.size() !== 12 || bz !== 1'b0) begin
      errors++;
      $display("FAIL en_disabled got beats=%0d busy=%b required beats=12 busy=0", cap_q.size(), bz);
    end
    drop_at = 0;
    en = 1'b1;
    run_idle(1500, "en_resume");
    compare_stream("en");
    checks++;
    if (cap_q.size() <= 12 || cap_q[12] !== 32'hCAFE0100) begin
      errors++;
      $display("FAIL en_resume_hdr got %h required cafe0100", (cap_q.size() > 12) ? cap_q[12] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] all_w[$];
    logic [31:0] w;
    int n;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      up_q.push_back(w);
      all_w.push_back(w);
    end
    en = 1'b1;
    drive_up();
    n = 0;
    while (pops < 20 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (pops !== 20) begin
      errors++;
      $display("FAIL rst_mid_pops got %0d required 20", pops);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov !== 1'b0 || od !== 32'h0 || rd !== 1'b0 || bz !== 1'b0 || fc !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got vld=%b dat=%h rd=%b busy=%b fcnt=%h required all 0", ov, od, rd, bz, fc);
    end
    step();
    step();
    rst = 1'b0;
    prev_stall = 1'b0;
    cap_q.delete(); cap_cyc.delete();
    for (int i = 20; i < 64; i++) exp_words.push_back(all_w[i]);
    exp_len.push_back(44);
    run_idle(1500, "rst_mid");
    compare_stream("rst_mid");
    checks++;
    if (fc !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_frame_cnt got %0d required 1", fc);
    end
  endtask

  task automatic test_seq_wrap();
    logic [31:0] w;
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 257; i++) begin
      w = $urandom;
      up_q.push_back(w);
      exp_words.push_back(w);
      exp_len.push_back(FL1);
    end
    en = 1'b1;
    drive_up();
    run_idle(2000, "wrap");
    compare_stream("wrap");
    checks++;
    if (fc !== 16'd257) begin
      errors++;
      $display("FAIL wrap_frame_cnt got %0d required 257", fc);
    end
    checks++;
    if (cap_q.size() < 771 || cap_q[255*3] !== 32'hCAFEFF00 || cap_q[256*3] !== 32'hCAFE0000) begin
      errors++;
      $display("FAIL wrap_seq got beats=%0d hdr255=%h hdr256=%h required cafeff00 cafe0000",
               cap_q.size(), (cap_q.size() > 765) ? cap_q[765] : 32'hx, (cap_q.size() > 768) ? cap_q[768] : 32'hx);
    end
    en = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_timeout();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
